// File: rtl/data_mem_responder.sv
// Data-side memory responder for a core LSU: a single-port word memory with
// req/gnt/rvalid handshake, programmable wait states, byte-lane stores and
// error reporting for out-of-range addresses or empty byte enables.
module data_mem_responder #(
    parameter int unsigned DEPTH        = 1024,
    parameter int unsigned WAIT_CYCLES  = 0,
    parameter int unsigned STALL_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    input  logic        stall_en_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o
);

    // Word index width into the array and wait counter width.
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(WAIT_CYCLES + STALL_CYCLES + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        GRANT = 2'd2,
        RESP  = 2'd3
    } state_t;

    logic [31:0] mem [0:DEPTH-1];

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [3:0]    be_q, be_d;
    logic [29:0]   widx_q, widx_d;
    logic [31:0]   wdata_q, wdata_d;

    logic          gnt_d;
    logic          rvalid_d;
    logic          err_d;
    logic [31:0]   rdata_d;

    logic [CW-1:0] wait_c;
    logic          err_c;
    logic [AW-1:0] idx_c;
    logic          unused_addr_lsb;

    // Byte offset within a word plays no part in addressing.
    assign unused_addr_lsb = ^data_addr_i[1:0];

    // Wait states for a request accepted this cycle.
    assign wait_c = CW'(WAIT_CYCLES) + (stall_en_i ? CW'(STALL_CYCLES) : CW'(0));

    // Error and array index derived from the captured transaction.
    assign err_c = (32'(widx_q) >= 32'(DEPTH)) || (be_q == 4'b0000);
    assign idx_c = widx_q[AW-1:0];

    // Next-state, capture and registered-output logic.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        be_d     = be_q;
        widx_d   = widx_q;
        wdata_d  = wdata_q;
        rvalid_d = 1'b0;
        err_d    = 1'b0;
        rdata_d  = data_rdata_o;

        case (state_q)
            IDLE, RESP: begin
                if (data_req_i) begin
                    we_d    = data_we_i;
                    be_d    = data_be_i;
                    widx_d  = data_addr_i[31:2];
                    wdata_d = data_wdata_i;
                    if (wait_c == CW'(0)) begin
                        state_d = GRANT;
                    end else begin
                        cnt_d   = wait_c;
                        state_d = WAIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = GRANT;
                end
            end
            GRANT: begin
                state_d  = RESP;
                rvalid_d = 1'b1;
                if (err_c) begin
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                end else if (!we_q) begin
                    rdata_d = mem[idx_c];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        gnt_d = (state_d == GRANT);
    end

    // State, capture and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            we_q          <= 1'b0;
            be_q          <= 4'b0000;
            widx_q        <= '0;
            wdata_q       <= 32'h0;
            data_gnt_o    <= 1'b0;
            data_rvalid_o <= 1'b0;
            data_rdata_o  <= 32'h0;
            data_err_o    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            we_q          <= we_d;
            be_q          <= be_d;
            widx_q        <= widx_d;
            wdata_q       <= wdata_d;
            data_gnt_o    <= gnt_d;
            data_rvalid_o <= rvalid_d;
            data_rdata_o  <= rdata_d;
            data_err_o    <= err_d;
        end
    end

    // Byte-lane store in GRANT; contents are never cleared so preloads survive reset.
    always_ff @(posedge clk) begin
        if (rst_n && (state_q == GRANT) && we_q && !err_c) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_c][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed vector table,
// back-to-back and reset-abort sequences, then random traffic against a model.
module tb_data_mem_responder;

    localparam int unsigned DEPTH  = 1024;
    localparam int unsigned WAITC  = 0;
    localparam int unsigned STALLC = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    int tests = 0;
    int fails = 0;

    logic [31:0] ref_mem [0:DEPTH-1];
    logic [31:0] ref_rdata;

    data_mem_responder #(
        .DEPTH        (DEPTH),
        .WAIT_CYCLES  (WAITC),
        .STALL_CYCLES (STALLC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .data_req_i    (req),
        .data_we_i     (we),
        .data_be_i     (be),
        .data_addr_i   (addr),
        .data_wdata_i  (wdata),
        .stall_en_i    (stall),
        .data_gnt_o    (gnt),
        .data_rvalid_o (rvalid),
        .data_rdata_o  (rdata),
        .data_err_o    (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        stall;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_w;
        logic        chk_mem;
        int          mem_idx;
        logic [31:0] exp_mem;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Spec-level model: latency, error rule, lane merge and held read data.
    task automatic model(input logic m_we, input logic [3:0] m_be, input logic [31:0] m_addr,
                         input logic [31:0] m_wd, input logic m_stall,
                         output int lat, output logic [31:0] rd, output logic e);
        int unsigned idx;
        idx = int'(m_addr >> 2);
        e   = (idx >= DEPTH) || (m_be == 4'b0000);
        lat = int'(WAITC) + (m_stall ? int'(STALLC) : 0);
        if (e) begin
            ref_rdata = 32'h0;
        end else if (m_we) begin
            for (int b = 0; b < 4; b++)
                if (m_be[b]) ref_mem[idx][8*b +: 8] = m_wd[8*b +: 8];
        end else begin
            ref_rdata = ref_mem[idx];
        end
        rd = ref_rdata;
    endtask

    // Issue one transaction and observe its handshake timing and response.
    task automatic run_txn(input logic t_we, input logic [3:0] t_be, input logic [31:0] t_addr,
                           input logic [31:0] t_wd, input logic t_stall,
                           output int gk, output int rk, output logic [31:0] rd,
                           output logic e, output int ngnt, output logic leak);
        req = 1'b1; we = t_we; be = t_be; addr = t_addr; wdata = t_wd; stall = t_stall;
        gk = -1; rk = -1; rd = 32'h0; e = 1'b0; ngnt = 0; leak = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            stall = ~t_stall;
            if (gnt) begin
                ngnt++;
                gk    = k;
                req   = 1'b0;
                addr  = ~t_addr;
                wdata = ~t_wd;
                be    = ~t_be;
            end
            if (err && !rvalid) leak = 1'b1;
            if (rvalid) begin
                rk = k;
                rd = rdata;
                e  = err;
                break;
            end
        end
    endtask

    task automatic check_txn(input string name, input int w, input logic [31:0] exp_rd,
                             input logic exp_e, input int gk, input int rk,
                             input logic [31:0] rd, input logic e, input int ngnt,
                             input logic leak);
        check({name, " gnt_latency"}, 32'(gk), 32'(w + 1));
        check({name, " rvalid_latency"}, 32'(rk), 32'(w + 2));
        check({name, " gnt_pulses"}, 32'(ngnt), 32'd1);
        check({name, " rdata"}, rd, exp_rd);
        check({name, " err"}, 32'(e), 32'(exp_e));
        check({name, " err_without_rvalid"}, 32'(leak), 32'd0);
    endtask

    initial begin
        int          gk, rk, ngnt, lat;
        logic [31:0] rd, mrd;
        logic        e, me, leak;
        int          rv_cyc [$];
        logic [31:0] rv_dat [$];
        int          ai;

        req = 1'b0; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0; stall = 1'b0;
        rst_n = 1'b0;
        ref_rdata = 32'h0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = $urandom;
        ref_mem[2]    = 32'h1122_3344;
        ref_mem[3]    = 32'h0000_0000;
        ref_mem[4]    = 32'hDEAD_BEEF;
        ref_mem[1023] = 32'hA5A5_5A5A;
        for (int i = 0; i < int'(DEPTH); i++) dut.mem[i] = ref_mem[i];

        vecs[0]  = '{1'b0, 4'hF, 32'h0000_0010, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 0, 32'h0};
        vecs[1]  = '{1'b1, 4'b0100, 32'h0000_0008, 32'h00AA_0000, 1'b0, 32'hDEAD_BEEF, 1'b0, 0, 1'b1, 2, 32'h11AA_3344};
        vecs[2]  = '{1'b0, 4'hF, 32'h0000_0008, 32'h0, 1'b0, 32'h11AA_3344, 1'b0, 0, 1'b0, 0, 32'h0};
        vecs[3]  = '{1'b1, 4'hF, 32'h0000_000C, 32'hCAFE_F00D, 1'b1, 32'h11AA_3344, 1'b0, 3, 1'b1, 3, 32'hCAFE_F00D};
        vecs[4]  = '{1'b0, 4'hF, 32'h0000_000C, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b0, 0, 1'b0, 0, 32'h0};
        vecs[5]  = '{1'b0, 4'hF, 32'h0000_1000, 32'h0, 1'b0, 32'h0, 1'b1, 0, 1'b0, 0, 32'h0};
        vecs[6]  = '{1'b1, 4'h0, 32'h0000_0010, 32'h1234_5678, 1'b0, 32'h0, 1'b1, 0, 1'b1, 4, 32'hDEAD_BEEF};
        vecs[7]  = '{1'b0, 4'hF, 32'h0000_0013, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 0, 32'h0};
        vecs[8]  = '{1'b0, 4'hF, 32'h0000_0FFC, 32'h0, 1'b1, 32'hA5A5_5A5A, 1'b0, 3, 1'b0, 0, 32'h0};
        vecs[9]  = '{1'b0, 4'hF, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'h0, 1'b1, 3, 1'b0, 0, 32'h0};
        vecs[10] = '{1'b1, 4'b1001, 32'h0000_0008, 32'hBB00_00CC, 1'b0, 32'h0, 1'b0, 0, 1'b1, 2, 32'hBBAA_33CC};
        vecs[11] = '{1'b0, 4'hF, 32'h0000_0008, 32'h0, 1'b0, 32'hBBAA_33CC, 1'b0, 0, 1'b0, 0, 32'h0};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("reset gnt", 32'(gnt), 32'd0);
        check("reset rvalid", 32'(rvalid), 32'd0);
        check("reset rdata", rdata, 32'h0);
        check("reset err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // Directed vectors, first one sampled on the first edge after release.
        for (int v = 0; v < 12; v++) begin
            model(vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata, vecs[v].stall, lat, mrd, me);
            run_txn(vecs[v].we, vecs[v].be, vecs[v].addr, vecs[v].wdata, vecs[v].stall,
                    gk, rk, rd, e, ngnt, leak);
            check_txn($sformatf("vec%0d", v), vecs[v].exp_w, vecs[v].exp_rdata, vecs[v].exp_err,
                      gk, rk, rd, e, ngnt, leak);
            if (vecs[v].chk_mem)
                check($sformatf("vec%0d mem", v), dut.mem[vecs[v].mem_idx], vecs[v].exp_mem);
        end

        // Back-to-back loads with req held high.
        ai = 0;
        req = 1'b1; we = 1'b0; be = 4'hF; addr = 32'h0; stall = 1'b0;
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk); #1;
            if (gnt) begin
                ai++;
                if (ai < 3) addr = 32'(ai * 4);
                else req = 1'b0;
            end
            if (rvalid) begin
                rv_cyc.push_back(cyc);
                rv_dat.push_back(rdata);
                if (rv_dat.size() == 3) break;
            end
        end
        check("b2b count", 32'(rv_dat.size()), 32'd3);
        if (rv_dat.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("b2b data%0d", i), rv_dat[i], ref_mem[i]);
                if (i > 0) check($sformatf("b2b spacing%0d", i), 32'(rv_cyc[i] - rv_cyc[i-1]), 32'd2);
            end
        end
        ref_rdata = ref_mem[2];

        // Reset while a stalled store sits in WAIT.
        req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h0000_0014; wdata = 32'h55AA_55AA; stall = 1'b1;
        @(posedge clk); #1;
        check("abort pre gnt", 32'(gnt), 32'd0);
        check("abort pre rdata", rdata, ref_rdata);
        req = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort gnt", 32'(gnt), 32'd0);
        check("abort rvalid", 32'(rvalid), 32'd0);
        check("abort rdata", rdata, 32'h0);
        check("abort err", 32'(err), 32'd0);
        rst_n = 1'b1;
        ref_rdata = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        check("abort mem", dut.mem[5], ref_mem[5]);
        model(1'b0, 4'hF, 32'h0000_0014, 32'h0, 1'b0, lat, mrd, me);
        run_txn(1'b0, 4'hF, 32'h0000_0014, 32'h0, 1'b0, gk, rk, rd, e, ngnt, leak);
        check_txn("post_abort load", lat, mrd, me, gk, rk, rd, e, ngnt, leak);

        // Random traffic against the model.
        for (int n = 0; n < 300; n++) begin
            logic        r_we, r_stall;
            logic [3:0]  r_be;
            logic [31:0] r_addr, r_wd;
            r_we    = 1'($urandom_range(1));
            r_stall = 1'($urandom_range(1));
            r_be    = ($urandom_range(9) == 0) ? 4'h0 : 4'($urandom_range(15, 1));
            r_wd    = $urandom;
            case ($urandom_range(7))
                0:       r_addr = $urandom;
                1:       r_addr = 32'(DEPTH * 4 + $urandom_range(255));
                default: r_addr = 32'($urandom_range(63));
            endcase
            if ($urandom_range(3) == 0) begin
                req = 1'b0;
                @(posedge clk); #1;
            end
            model(r_we, r_be, r_addr, r_wd, r_stall, lat, mrd, me);
            run_txn(r_we, r_be, r_addr, r_wd, r_stall, gk, rk, rd, e, ngnt, leak);
            check_txn($sformatf("rand%0d", n), lat, mrd, me, gk, rk, rd, e, ngnt, leak);
        end
        for (int i = 0; i < 16; i++)
            check($sformatf("final mem%0d", i), dut.mem[i], ref_mem[i]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the number of 32-bit words in the memory array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 0, meaning the number of base wait states inserted before grant.
REQ-003 SHALL have parameter STALL_CYCLES, default 3, meaning the extra wait states added when stall_en_i is high.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port data_req_i, input, 1, the load/store request from the core LSU.
REQ-007 SHALL have port data_we_i, input, 1, where 1 = store and 0 = load.
REQ-008 SHALL have port data_be_i, input, 4, the byte enables, already aligned by the LSU.
REQ-009 SHALL have port data_addr_i, input, 32, the byte address.
REQ-010 SHALL have port data_wdata_i, input, 32, the store data, already lane-aligned.
REQ-011 SHALL have port stall_en_i, input, 1, the wait-state injection enable.
REQ-012 SHALL have port data_gnt_o, output, 1, the request-accepted pulse.
REQ-013 SHALL have port data_rvalid_o, output, 1, the response-valid pulse.
REQ-014 SHALL have port data_rdata_o, output, 32, the load data.
REQ-015 SHALL have port data_err_o, output, 1, the error flag, qualified by data_rvalid_o.
REQ-016 SHALL name its storage array "mem", declared [0:DEPTH-1] of 32 bits, so benches can preload it hierarchically with $readmemh.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, GRANT and RESP; all outputs SHALL be registered.
REQ-018 SHALL, in IDLE or RESP with data_req_i=1: capture we, be, addr and wdata; compute W = WAIT_CYCLES + (stall_en_i ? STALL_CYCLES : 0); go to GRANT if W=0, otherwise load cnt=W and go to WAIT.
REQ-019 SHALL, in IDLE or RESP with data_req_i=0, go to IDLE.
REQ-020 SHALL, in WAIT, decrement cnt each cycle and go to GRANT on the cycle cnt=1; stall_en_i changes after capture SHALL have no effect.
REQ-021 SHALL assert data_gnt_o for exactly one cycle in GRANT.
REQ-022 SHALL, in GRANT on a store, write each byte lane whose captured be bit is set and leave all other lanes unchanged.
REQ-023 SHALL, in GRANT on a load, read the full word into data_rdata_o; the output SHALL hold until the next load response or an error.
REQ-024 SHALL assert data_rvalid_o for exactly one cycle, in RESP; latency is gnt = W+1 cycles and rvalid = W+2 cycles after the cycle data_req_i is first sampled.
REQ-025 SHALL, on a store response, leave data_rdata_o unchanged.
REQ-026 SHALL index words as word index = addr[31:2]; addr[1:0] SHALL be ignored.
REQ-027 SHALL raise an error when word index >= DEPTH or captured be = 4'b0000.
REQ-028 SHALL, on an error, perform no write, drive data_rdata_o to 0 and assert data_err_o together with data_rvalid_o; data_err_o SHALL be 0 whenever data_rvalid_o=0.
REQ-029 SHALL support back-to-back requests from RESP with no IDLE bubble, giving one transaction every W+2 cycles.
REQ-030 SHALL ignore data_req_i in WAIT and GRANT; the initiator holds req and its fields stable until gnt.

Reset
REQ-031 SHALL, while rst_n=0 at a clock edge, set state=IDLE, cnt=0, data_gnt_o=0, data_rvalid_o=0, data_rdata_o=0 and data_err_o=0.
REQ-032 SHALL NOT clear mem contents on reset, so preloaded data survives.
REQ-033 SHALL abort any in-flight transaction (WAIT/GRANT/RESP) on reset; a store not yet in GRANT SHALL NOT be written.
REQ-034 SHALL sample data_req_i with rst_n=1 in the first cycle after reset release.

Verification
REQ-035 SHALL verify a load with W=0: mem[4] preloaded 0xDEADBEEF, req at addr 0x10 -> gnt at +1, rvalid at +2, rdata=0xDEADBEEF, err=0.
REQ-036 SHALL verify a byte-lane store: mem[2]=0x11223344, store addr 0x08 be=4'b0100 wdata=0x00AA0000 -> mem[2]=0x11AA3344, then a load returns 0x11AA3344.
REQ-037 SHALL verify a stalled store: stall_en_i=1, WAIT_CYCLES=0, store addr 0x0C be=4'hF wdata=0xCAFEF00D -> gnt at +4, rvalid at +5, mem[3]=0xCAFEF00D.
REQ-038 SHALL verify error cases: load at addr 0x1000 with DEPTH=1024 -> rvalid+err, rdata=0; store with be=0 -> err and mem unchanged.
REQ-039 SHALL verify back-to-back traffic: three loads at 0x0, 0x4, 0x8 with req held -> rvalid every 2 cycles with correct data in order.
REQ-040 SHALL verify reset mid-operation: stall_en_i=1 store, rst_n=0 in WAIT -> all outputs 0 next cycle, mem unchanged, and a subsequent load succeeds.
